// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock, sign fix-up in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_b;
    logic               is_mul;
    logic               neg_hi;
    logic               neg_lo;
    logic               dbz_pend;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Operand decode; op[0]==0 selects the signed variants
    logic             arith_go, is_div_op, b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        arith_go  = start && !op[2];
        is_div_op = op[1];
        b_zero    = (b == '0);
        a_neg     = !op[0] && a[WIDTH-1];
        b_neg     = !op[0] && b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // One iteration step for each operation
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH-1:0]   div_sub;
    logic               div_fits;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_rs   = acc[2*WIDTH-1:WIDTH-1];
        div_fits = (div_rs >= {1'b0, mag_b});
        div_sub  = div_rs[WIDTH-1:0] - mag_b;
        div_next = div_fits ? {div_sub, acc[WIDTH-2:0], 1'b1}
                            : {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (arith_go) state_next = (is_div_op && b_zero) ? FIX : CALC;
            CALC: if (cnt == CW'(ITER - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mag_b       <= '0;
            is_mul      <= 1'b0;
            neg_hi      <= 1'b0;
            neg_lo      <= 1'b0;
            dbz_pend    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_next;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (arith_go) begin
                        cnt    <= '0;
                        is_mul <= !is_div_op;
                        mag_b  <= b_mag;
                        if (is_div_op && b_zero) begin
                            // Result preloaded so FIX writes it through unmodified
                            acc      <= {a, {WIDTH{1'b1}}};
                            neg_hi   <= 1'b0;
                            neg_lo   <= 1'b0;
                            dbz_pend <= 1'b1;
                        end else begin
                            acc      <= {{WIDTH{1'b0}}, a_mag};
                            neg_lo   <= a_neg ^ b_neg;
                            neg_hi   <= is_div_op ? a_neg : (a_neg ^ b_neg);
                            dbz_pend <= 1'b0;
                        end
                    end else if (start && op == 3'b100) begin
                        hi_q <= a;
                    end else if (start && op == 3'b101) begin
                        lo_q <= a;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_mul ? mul_next : div_next;
                end
                FIX: begin
                    if (is_mul) begin
                        {hi_q, lo_q} <= neg_lo ? -acc : acc;
                    end else begin
                        hi_q <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo_q <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end
                    done        <= 1'b1;
                    div_by_zero <= dbz_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign hi_out = hi_q;
    assign lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, latency, reset abort and MTHI/MTLO.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi_out, lo_out;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents a request for one edge (E0); returns #1 after E0
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called #1 after E0; returns #1 after the edge that raised done
    task automatic wait_result(input string tag, input int exp_lat, input logic exp_dbz);
        int n, bc;
        logic [63:0] e;
        n = 0; bc = 0;
        while (!done && n < 200) begin
            if (busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        chk({tag, "_hilo"}, {hi_out, lo_out}, e);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp_hilo,
                          input int exp_lat, input logic exp_dbz);
        exp_q.push_back(exp_hilo);
        issue(o, x, y);
        wait_result(tag, exp_lat, exp_dbz);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 1'b0);
        run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33, 1'b0);
        run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, 1'b0);
        run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 64'h0000_0001_0000_0003, 33, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 1'b0);
        run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, 1'b0);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1, 1'b1);
        run_op("div_by0", OP_DIV, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, 1, 1'b1);

        // Abort: second start ignored mid-op, reset at E10 discards everything
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_busy_mid", 64'(busy), 64'd1);
        chk("abort_hilo_held", {hi_out, lo_out}, 64'hFFFF_FFF0_FFFF_FFFF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi_out, lo_out}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
        @(posedge clk); #1;
        chk("mthi_hi", 64'(hi_out), 64'h1234_5678);
        chk("mthi_flags", {62'd0, busy, done}, 64'd0);
        op = OP_MTLO; a = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_hilo", {hi_out, lo_out}, 64'h1234_5678_9ABC_DEF0);
        chk("mtlo_flags", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        chk("mt_no_done", {62'd0, busy, done}, 64'd0);

        // Unused opcode does nothing
        issue(3'b110, 32'h5555_5555, 32'd1);
        chk("op110_idle", {31'd0, busy, hi_out, lo_out}, {32'd0, 64'h1234_5678_9ABC_DEF0});

        // Back-to-back: new request presented in the done cycle
        exp_q.push_back(64'd6);
        issue(OP_MULTU, 32'd2, 32'd3);
        wait_result("b2b_first", 33, 1'b0);
        start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_accepted", 64'(busy), 64'd1);
        exp_q.push_back(64'd30);
        wait_result("b2b_second", 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
